// File: rtl/pll_lock_ctrl.sv
// PLL supervisor on the reference clock: pulses the PLL reset, waits for a
// debounced lock, then releases the PLL-domain system reset; retries or fails on timeout.
module pll_lock_ctrl #(
    parameter int LOCK_SYNC_STAGES = 2,
    parameter int PLL_RST_CYCLES   = 27,
    parameter int LOCK_TIMEOUT     = 270000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRIES      = 7
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock_i,
    input  logic       clear_i,
    output logic       pll_reset_o,
    output logic       sys_resetn_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [7:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    localparam int MAX_AB = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAX_T  = (MAX_AB > PLL_RST_CYCLES) ? MAX_AB : PLL_RST_CYCLES;
    localparam int TW     = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] RST_LAST  = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STAB_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic [7:0]                  retry_q, retry_d;
    logic [7:0]                  loss_q,  loss_d;
    logic [LOCK_SYNC_STAGES-1:0] sync_q;
    logic                        lock_s;
    logic                        tmr_inc;

    // Lock is asynchronous to clk; only the last stage is consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= '0;
        else         sync_q <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_lock_i};
    end

    assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RST_PLL;
            timer_q <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        tmr_inc = 1'b0;
        case (state_q)
            RST_PLL: begin
                tmr_inc = 1'b1;
                if (timer_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                tmr_inc = 1'b1;
                if (lock_s) begin
                    state_d = STABLE;
                end else if (timer_q == TO_LAST) begin
                    retry_d = retry_q + 8'd1;
                    state_d = (retry_d == RETRY_MAX) ? FAIL : RST_PLL;
                end
            end
            STABLE: begin
                tmr_inc = 1'b1;
                // A lost lock here is a glitch, not a retry: back to WAIT_LOCK with a fresh timeout.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == STAB_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = RST_PLL;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            FAIL: begin
                if (clear_i) begin
                    retry_d = '0;
                    state_d = RST_PLL;
                end
            end
            default: state_d = RST_PLL;
        endcase
        // Clear wins over a simultaneous loss increment.
        if (clear_i) loss_d = '0;
        if (state_d != state_q) timer_d = '0;
        else if (tmr_inc)       timer_d = timer_q + 1'b1;
        else                    timer_d = timer_q;
    end

    assign pll_reset_o  = (state_q == RST_PLL);
    assign sys_resetn_o = (state_q == RUN);
    assign locked_o     = (state_q == RUN);
    assign fail_o       = (state_q == FAIL);
    assign retry_cnt_o  = retry_q;
    assign loss_cnt_o   = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: table of acquisition/loss steps plus
// hand sequences for glitch, timeout, failure, saturation and async reset.
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       pll_reset_o, sys_resetn_o, locked_o, fail_o;
    logic [7:0] retry_cnt_o, loss_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pll_lock_ctrl #(
        .LOCK_SYNC_STAGES(2),
        .PLL_RST_CYCLES  (4),
        .LOCK_TIMEOUT    (20),
        .STABLE_CYCLES   (8),
        .MAX_RETRIES     (3)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pll_lock_i  (pll_lock_i),
        .clear_i     (clear_i),
        .pll_reset_o (pll_reset_o),
        .sys_resetn_o(sys_resetn_o),
        .locked_o    (locked_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o),
        .loss_cnt_o  (loss_cnt_o)
    );

    typedef struct {
        string nm;
        bit    lock;
        bit    clr;
        int    n;
        bit    e_prst, e_sys, e_lck, e_fail;
        int    e_retry, e_loss;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input bit prst, input bit sys, input bit lck,
                           input bit fl, input int retry, input int loss);
        chk({nm, ".pll_reset"}, int'(pll_reset_o), int'(prst));
        chk({nm, ".sys_resetn"}, int'(sys_resetn_o), int'(sys));
        chk({nm, ".locked"}, int'(locked_o), int'(lck));
        chk({nm, ".fail"}, int'(fail_o), int'(fl));
        chk({nm, ".retry"}, int'(retry_cnt_o), retry);
        chk({nm, ".loss"}, int'(loss_cnt_o), loss);
    endtask

    // Advance n rising edges, returning at the following falling edge.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_run(input string nm);
        int k = 0;
        while (!sys_resetn_o && k < 100) begin
            adv(1);
            k++;
        end
        chk({nm, ".wait_run"}, int'(sys_resetn_o), 1);
    endtask

    initial begin
        //          name            lock clr n  prst sys lck fail retry loss
        vecs[0]  = '{"rst_hold",     1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{"rst_fall",     1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[2]  = '{"wait_nolock",  1'b0, 1'b0, 9,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[3]  = '{"pre_release",  1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[4]  = '{"release",      1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[5]  = '{"run_hold",     1'b1, 1'b0, 5,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[6]  = '{"loss_pre",     1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[7]  = '{"loss_fall",    1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
        vecs[8]  = '{"reacq_rst",    1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
        vecs[9]  = '{"reacq_wait",   1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
        vecs[10] = '{"reacq_stable", 1'b1, 1'b0, 8,  1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
        vecs[11] = '{"reacq_run",    1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
        vecs[12] = '{"run_clear",    1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[13] = '{"run_after_clr",1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0};

        // Reset state
        @(negedge clk);
        chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        resetn = 1'b1;

        // Normal acquisition, loss, re-acquisition, clear in RUN
        foreach (vecs[i]) begin
            pll_lock_i = vecs[i].lock;
            clear_i    = vecs[i].clr;
            adv(vecs[i].n);
            chk_all(vecs[i].nm, vecs[i].e_prst, vecs[i].e_sys, vecs[i].e_lck,
                    vecs[i].e_fail, vecs[i].e_retry, vecs[i].e_loss);
        end
        clear_i = 1'b0;

        // Lock glitch in STABLE
        pll_lock_i = 1'b0;
        adv(3);
        chk_all("gl_loss", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1);
        adv(4);
        chk("gl_wait.pll_reset", int'(pll_reset_o), 0);
        pll_lock_i = 1'b1;
        adv(7);
        pll_lock_i = 1'b0;
        adv(2);
        chk_all("gl_low", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        pll_lock_i = 1'b1;
        adv(10);
        chk_all("gl_pre", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        adv(1);
        chk_all("gl_release", 1'b0, 1'b1, 1'b1, 1'b0, 0, 1);

        // Async reset mid-cycle while in RUN
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 chk_all("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        pll_lock_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        adv(3);
        chk("ar_restart_hi", int'(pll_reset_o), 1);
        adv(1);
        chk("ar_restart_lo", int'(pll_reset_o), 0);

        // Three timeouts into FAIL, then clear
        adv(19);
        chk_all("to1_pre", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        adv(1);
        chk_all("to1", 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        adv(3);
        chk("to1_pulse_hi", int'(pll_reset_o), 1);
        adv(1);
        chk("to1_pulse_lo", int'(pll_reset_o), 0);
        adv(19);
        chk("to2_pre.retry", int'(retry_cnt_o), 1);
        adv(1);
        chk_all("to2", 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
        adv(23);
        chk_all("to3_pre", 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
        adv(1);
        chk_all("fail", 1'b0, 1'b0, 1'b0, 1'b1, 3, 0);
        adv(5);
        chk_all("fail_hold", 1'b0, 1'b0, 1'b0, 1'b1, 3, 0);
        clear_i = 1'b1;
        adv(1);
        clear_i = 1'b0;
        chk_all("fail_clear", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Single timeout, then lock on the second attempt
        adv(3);
        chk("st_rst_hi", int'(pll_reset_o), 1);
        adv(1);
        chk("st_rst_lo", int'(pll_reset_o), 0);
        adv(19);
        chk_all("st_to_pre", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        adv(1);
        chk_all("st_to", 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        adv(4);
        chk_all("st_attempt2", 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        pll_lock_i = 1'b1;
        adv(10);
        chk_all("st_pre_run", 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        adv(1);
        chk_all("st_run", 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);

        // Loss counter saturation
        @(negedge clk);
        resetn = 1'b0;
        pll_lock_i = 1'b0;
        #2 resetn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            pll_lock_i = 1'b1;
            wait_run($sformatf("sat%0d", i));
            pll_lock_i = 1'b0;
            adv(3);
        end
        chk_all("sat", 1'b1, 1'b0, 1'b0, 1'b0, 0, 255);

        // Clear coinciding with a loss
        pll_lock_i = 1'b1;
        wait_run("clrloss");
        pll_lock_i = 1'b0;
        adv(2);
        chk("clrloss_pre.loss", int'(loss_cnt_o), 255);
        clear_i = 1'b1;
        adv(1);
        clear_i = 1'b0;
        chk_all("clrloss", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
